// File: rtl/updown_counter_mod.sv
// Purpose: parametrised up/down counter with run-time modulus (0..max_val),
//          parallel load, wrap or saturate at the bounds, a registered
//          terminal-count flag and a sticky overflow flag.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   en        in  1      count enable
//   up        in  1      direction, 1 = increment, 0 = decrement
//   load      in  1      parallel load strobe (beats en)
//   load_val  in  WIDTH  load value, clamped to max_val
//   max_val   in  WIDTH  upper bound of the counting range
//   clr_flag  in  1      clears ovf (a boundary event in the same cycle wins)
//   dout      out WIDTH  current count
//   tc        out 1      high for the cycle after each boundary step
//   ovf       out 1      sticky boundary-crossing flag
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] Zero     = '0;
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // Step result of an enabled, non-load cycle, kept separate from priority.
  logic [WIDTH-1:0] step_val;
  logic             boundary;

  // Count step: clamp when the bound dropped below the count, else
  // increment/decrement with wrap or hold at 0 and max_val.
  always_comb begin
    step_val = dout_q;
    boundary = 1'b0;
    if (dout_q > max_val) begin
      step_val = max_val;
    end else if (up) begin
      if (dout_q == max_val) begin
        boundary = 1'b1;
        step_val = SATURATE ? max_val : Zero;
      end else begin
        step_val = dout_q + One;
      end
    end else begin
      if (dout_q == Zero) begin
        boundary = 1'b1;
        step_val = SATURATE ? Zero : max_val;
      end else begin
        step_val = dout_q - One;
      end
    end
  end

  // Next state with priority rst > load > en; tc defaults low every cycle.
  always_comb begin
    dout_d = dout_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;
    if (rst) begin
      dout_d = RstCount;
      ovf_d  = 1'b0;
    end else begin
      if (load) begin
        dout_d = (load_val > max_val) ? max_val : load_val;
      end else if (en) begin
        dout_d = step_val;
      end
      if (clr_flag) begin
        ovf_d = 1'b0;
      end
      // Set beats clear when both happen in one cycle.
      if (!load && en && boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    dout_q <= dout_d;
    tc_q   <= tc_d;
    ovf_q  <= ovf_d;
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: one wrapping and one saturating
// instance share stimulus; expected values are hand-derived.
module tb_updown_counter_mod;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, en, up, load, clr_flag;
  logic [W-1:0] load_val, max_val;

  logic [W-1:0] a_dout, s_dout;
  logic         a_tc, a_ovf, s_tc, s_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(W), .SATURATE(1'b0), .RST_VAL(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_flag(clr_flag),
    .dout(a_dout), .tc(a_tc), .ovf(a_ovf)
  );

  updown_counter_mod #(.WIDTH(W), .SATURATE(1'b1), .RST_VAL(0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_flag(clr_flag),
    .dout(s_dout), .tc(s_tc), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; clr_flag = 1'b0;
    load_val = '0; max_val = 8'd255;
    tick();
    chk("reset_dout", 32'(a_dout), 0);
    chk("reset_tc",   32'(a_tc),   0);
    chk("reset_ovf",  32'(a_ovf),  0);
    chk("reset_sat_dout", 32'(s_dout), 0);

    // Wrap up over the full 8-bit range.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("up255_dout", 32'(a_dout), 255);
    chk("up255_tc",   32'(a_tc),   0);
    chk("up255_ovf",  32'(a_ovf),  0);
    tick();
    chk("wrap_dout", 32'(a_dout), 0);
    chk("wrap_tc",   32'(a_tc),   1);
    chk("wrap_ovf",  32'(a_ovf),  1);
    en = 1'b0;
    tick();
    chk("wrap_tc_pulse_end", 32'(a_tc), 0);
    chk("hold_dout",         32'(a_dout), 0);
    chk("ovf_sticky",        32'(a_ovf), 1);
    clr_flag = 1'b1;
    tick();
    chk("clr_ovf", 32'(a_ovf), 0);
    clr_flag = 1'b0;

    // Wrap down with max_val=9.
    max_val = 8'd9; up = 1'b0; en = 1'b1;
    tick();
    chk("down_wrap_dout", 32'(a_dout), 9);
    chk("down_wrap_tc",   32'(a_tc),   1);
    chk("down_wrap_ovf",  32'(a_ovf),  1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("down_dout", 32'(a_dout), 32'(9 - i));
      chk("down_tc",   32'(a_tc),   0);
    end
    en = 1'b0;

    // Saturate up at max_val=100 (saturating instance).
    rst = 1'b1;
    tick();
    rst = 1'b0; max_val = 8'd100; up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      chk("sat_dout", 32'(s_dout), (i < 100) ? 32'(i) : 32'd100);
      chk("sat_tc",   32'(s_tc),   (i >= 101) ? 32'd1 : 32'd0);
    end
    chk("sat_ovf", 32'(s_ovf), 1);
    up = 1'b0;
    tick();
    chk("sat_down_dout", 32'(s_dout), 99);
    chk("sat_down_tc",   32'(s_tc),   0);

    // Load clamping and priority, max_val=150.
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; max_val = 8'd150;
    load = 1'b1; load_val = 8'd200;
    tick();
    chk("load_clamp", 32'(a_dout), 150);
    chk("load_tc",    32'(a_tc),   0);
    en = 1'b1; up = 1'b1; load_val = 8'd42;
    tick();
    chk("load_over_en", 32'(a_dout), 42);
    chk("load_ovf_unchanged", 32'(a_ovf), 0);
    rst = 1'b1;
    tick();
    chk("rst_over_load", 32'(a_dout), 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // Enable gating, then count up and down.
    max_val = 8'd255;
    for (int i = 0; i < 100; i++) begin
      up = ~up;
      tick();
      chk("en0_dout", 32'(a_dout), 0);
      chk("en0_tc",   32'(a_tc),   0);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 156; i++) tick();
    chk("up156_dout", 32'(a_dout), 156);
    up = 1'b0;
    for (int i = 0; i < 75; i++) tick();
    chk("down75_dout", 32'(a_dout), 81);
    rst = 1'b1;
    tick();
    chk("rst_mid_dout", 32'(a_dout), 0);
    chk("rst_mid_ovf",  32'(a_ovf),  0);
    rst = 1'b0;

    // Run-time bound lowered below the count.
    en = 1'b0; load = 1'b1; load_val = 8'd50;
    tick();
    chk("load50", 32'(a_dout), 50);
    load = 1'b0; max_val = 8'd20; en = 1'b1; up = 1'b1;
    tick();
    chk("lower_clamp_dout", 32'(a_dout), 20);
    chk("lower_clamp_tc",   32'(a_tc),   0);
    chk("lower_clamp_ovf",  32'(a_ovf),  0);
    clr_flag = 1'b1;
    tick();
    chk("lower_wrap_dout", 32'(a_dout), 0);
    chk("lower_wrap_tc",   32'(a_tc),   1);
    chk("set_beats_clr",   32'(a_ovf),  1);
    en = 1'b0;
    tick();
    chk("clr_after_set", 32'(a_ovf), 0);
    clr_flag = 1'b0;

    // max_val=0: every enabled step is a boundary event.
    max_val = 8'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up = ~up;
      tick();
      chk("max0_dout", 32'(a_dout), 0);
      chk("max0_tc",   32'(a_tc),   1);
    end
    chk("max0_ovf", 32'(a_ovf), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
